// File: rtl/buzzer_round_ctrl_pkg.sv
// Shared definitions for the quiz-buzzer round controller.
//   state_t    : round FSM states
//   SEG_*      : seven-segment patterns, bit order abcdefg, active-high
//   NPLAYERS   : number of buzzer inputs
package buzzer_round_ctrl_pkg;

   localparam int unsigned NPLAYERS = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_LOCKED,
      ST_TIE,
      ST_TIMEOUT
   } state_t;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_E    = 7'b1001111;

   function automatic logic [6:0] seg_digit(input logic [2:0] d);
      case (d)
         3'd1:    return SEG_1;
         3'd2:    return SEG_2;
         3'd3:    return SEG_3;
         3'd4:    return SEG_4;
         default: return SEG_0;
      endcase
   endfunction

   // Player number (1..4) of a single asserted bit; 0 if not exactly one.
   function automatic logic [2:0] onehot_id(input logic [NPLAYERS-1:0] v);
      case (v)
         4'b0001: return 3'd1;
         4'b0010: return 3'd2;
         4'b0100: return 3'd3;
         4'b1000: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/buzzer_round_ctrl_debounce.sv
// One buzzer channel: 2-flop synchronizer, debouncer, rising-edge detect.
//   clk, rst : clock, async active-high reset
//   din      : raw asynchronous buzzer
//   rise     : one-cycle pulse when the debounced level goes high
module buzzer_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

   logic       s1, s2;
   logic [7:0] cnt;
   logic       deb, deb_q;

   // Level is accepted once the synced input has been high LIMIT cycles in a row.
   assign deb  = (cnt == LIMIT);
   assign rise = deb & ~deb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         deb_q <= 1'b0;
      end else begin
         s1    <= din;
         s2    <= s1;
         deb_q <= deb;
         if (!s2)
            cnt <= '0;
         else if (cnt != LIMIT)
            cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/buzzer_round_ctrl.sv
// Quiz buzzer round controller: arms on start, latches the first debounced
// press, flags ties, times out the answer window, drives a 7-seg display.
//   clk, rst            : clock, async active-high reset
//   start, clear        : host pulses (arm round / end round)
//   player[3:0]         : raw buzzers, bit i = player i+1
//   winner_valid        : single winner held (LOCKED)
//   winner_id, decimal  : latched player in LOCKED/TIMEOUT, else 0
//   display             : abcdefg pattern for the current state
//   tie, timeout, armed : state flags
module buzzer_round_ctrl
   import buzzer_round_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ANSWER_CYCLES   = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                clear,
   input  logic [NPLAYERS-1:0] player,
   output logic                winner_valid,
   output logic [2:0]          winner_id,
   output logic [6:0]          display,
   output logic [3:0]          decimal,
   output logic                tie,
   output logic                timeout,
   output logic                armed
);

   localparam logic [19:0] ACNT_LAST = 20'(ANSWER_CYCLES - 1);

   state_t              state, nstate;
   logic [NPLAYERS-1:0] rise;
   logic [2:0]          win_id, win_id_n;
   logic [19:0]         acnt;

   for (genvar g = 0; g < NPLAYERS; g++) begin : g_btn
      buzzer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .din  (player[g]),
         .rise (rise[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate   = state;
      win_id_n = win_id;
      case (state)
         ST_IDLE:   if (start) nstate = ST_ARMED;
         ST_ARMED: begin
            if (onehot_id(rise) != 3'd0) begin
               nstate   = ST_LOCKED;
               win_id_n = onehot_id(rise);
            end else if (rise != '0) begin
               nstate = ST_TIE;
            end
         end
         ST_LOCKED: if (acnt == ACNT_LAST) nstate = ST_TIMEOUT;
         default:   nstate = state;
      endcase
      if (clear) nstate = ST_IDLE;
      // The id register is only meaningful while a winner is held.
      if (nstate != ST_LOCKED && nstate != ST_TIMEOUT) win_id_n = 3'd0;
   end

   // Answer window counter: cleared on LOCKED entry, saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acnt <= '0;
      else if (nstate == ST_LOCKED && state != ST_LOCKED)
         acnt <= '0;
      else if (state == ST_LOCKED && acnt != '1)
         acnt <= acnt + 20'd1;
   end

   // Outputs are registered from the next state so they change with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_id       <= 3'd0;
         winner_valid <= 1'b0;
         display      <= SEG_0;
         tie          <= 1'b0;
         timeout      <= 1'b0;
         armed        <= 1'b0;
      end else begin
         win_id       <= win_id_n;
         winner_valid <= (nstate == ST_LOCKED);
         tie          <= (nstate == ST_TIE);
         timeout      <= (nstate == ST_TIMEOUT);
         armed        <= (nstate == ST_ARMED);
         case (nstate)
            ST_LOCKED:  display <= seg_digit(win_id_n);
            ST_TIE:     display <= SEG_DASH;
            ST_TIMEOUT: display <= SEG_E;
            default:    display <= SEG_0;
         endcase
      end
   end

   assign winner_id = win_id;
   assign decimal   = {1'b0, win_id};

endmodule

// File: doc/buzzer_round_ctrl.md
BUZZER_ROUND_CTRL -- requirements
Module: buzzer_round_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high cycles (synchronized) needed to accept a press, range 1..255.
REQ-002 SHALL have parameter ANSWER_CYCLES, default 1000: cycles allowed to answer after a win, range 1..2^20-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  host pulse arming a round (synchronous, one cycle).
REQ-006 SHALL have port clear  input  1  host pulse ending the round, returns to IDLE.
REQ-007 SHALL have port player  input  4  raw buzzers, bit i = player i+1, asynchronous, active-high.
REQ-008 SHALL have port winner_valid  output  1  high while a single winner is held.
REQ-009 SHALL have port winner_id  output  3  1..4 for winner, 0 otherwise.
REQ-010 SHALL have port display  output  7  seven-segment pattern abcdefg, active-high.
REQ-011 SHALL have port decimal  output  4  binary of winner_id (0 when no winner).
REQ-012 SHALL have ports tie, timeout, armed  output  1 each  state flags.

Function
REQ-013 SHALL pass each player bit through a 2-flop synchronizer, then a debouncer asserting once synced input is high DEBOUNCE_CYCLES consecutive cycles; any low sample zeroes the count and deasserts.
REQ-014 SHALL count only rising edges of debounced bits; buttons held when start arrives SHALL not win until released and re-pressed.
REQ-015 SHALL implement states IDLE, ARMED, LOCKED, TIE, TIMEOUT.
REQ-016 IDLE -> ARMED on start; ARMED: exactly one edge in a cycle -> LOCKED latching that player; two or more edges same cycle -> TIE; no edge -> stay.
REQ-017 In LOCKED, presses SHALL be ignored; an answer counter runs from 0, and after ANSWER_CYCLES cycles in LOCKED the FSM SHALL enter TIMEOUT.
REQ-018 clear SHALL force IDLE from any state on next edge; clear and start same cycle -> clear wins (IDLE); start outside IDLE ignored.
REQ-019 winner_valid SHALL rise DEBOUNCE_CYCLES+3 edges after first edge sampling a stable press, registered output.
REQ-020 winner_id/decimal SHALL hold latched player in LOCKED and TIMEOUT; 0 in other states.
REQ-021 display: IDLE/ARMED/TIE per code: 0 -> 1111110, TIE -> dash 0000001; LOCKED: 1 -> 0110000, 2 -> 1101101, 3 -> 1111001, 4 -> 0110011; TIMEOUT -> E 1001111.
REQ-022 Flags: armed=ARMED, tie=TIE, timeout=TIMEOUT, all registered; winner_valid=LOCKED only.
REQ-023 Answer counter SHALL saturate, never wrap, and reset to 0 on each LOCKED entry.

Reset
REQ-024 rst SHALL asynchronously force IDLE, synchronizers/debouncers/counters 0, winner_id 0, decimal 0, display 1111110, all flags 0.
REQ-025 rst mid-round SHALL discard latched winner; post-release needs a fresh start.

Structure
REQ-026 Shared package SHALL hold state enum, seven-segment constants (digits 0-4, dash, E), player width 4.
REQ-027 One sub-module buzzer_debounce (sync + debounce + edge, one per player, parameter DEBOUNCE_CYCLES); FSM, counter, display decode in top.

Verification
REQ-028 rst, start, press player 3 (0100) held -> at DEBOUNCE_CYCLES+3 edges winner_id=3, decimal=0011, display=1111001, winner_valid=1.
REQ-029 ARMED, players 1 and 2 (0011) rise same cycle -> tie=1, display=0000001, winner_id=0; clear -> IDLE, display=1111110.
REQ-030 Player 4 wins, player 1 pressed 10 cycles later -> winner_id stays 4; after ANSWER_CYCLES cycles timeout=1, display=1001111, decimal=0100.
REQ-031 Player 2 held before start, player 1 pressed after -> winner_id=1; 2-cycle glitch on player 3 (DEBOUNCE_CYCLES=4) -> ignored.
REQ-032 rst asserted in LOCKED -> all outputs reset values immediately (async); start+clear same cycle in IDLE -> stays IDLE, armed=0.
